// File: rtl/riscv_pkg.sv
// Shared RV64 core definitions: M-extension divide opcodes and divider FSM states.
// No logic; types and constants only.
package riscv_pkg;

    localparam logic [1:0] OP_DIV  = 2'b00;
    localparam logic [1:0] OP_DIVU = 2'b01;
    localparam logic [1:0] OP_REM  = 2'b10;
    localparam logic [1:0] OP_REMU = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU; XLEN+1 busy cycles, 1 for divide-by-zero/overflow.
// start is sampled only while idle; requests made while busy (including the done cycle) are dropped.
module div_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_t      state_q, state_d;
    logic [CW-1:0]   count_q, count_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] dsr_q, dsr_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            qneg_q, qneg_d;
    logic            rneg_q, rneg_d;
    logic            is_rem_q, is_rem_d;

    // One restoring step: quotient register shifts its MSB into the partial remainder.
    logic [XLEN:0]   rem_sh;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] rem_nx;
    logic [XLEN-1:0] quo_nx;

    assign rem_sh = {rem_q, quo_q[XLEN-1]};
    assign diff   = rem_sh - {1'b0, dsr_q};
    assign ge     = ~diff[XLEN];
    assign rem_nx = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nx = {quo_q[XLEN-2:0], ge};

    logic in_signed;
    logic in_rem;
    logic dvd_neg;
    logic dsr_neg;

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        dsr_d    = dsr_q;
        result_d = result_q;
        qneg_d   = qneg_q;
        rneg_d   = rneg_q;
        is_rem_d = is_rem_q;

        in_signed = (op == OP_DIV) || (op == OP_REM);
        in_rem    = (op == OP_REM) || (op == OP_REMU);
        dvd_neg   = in_signed & dividend[XLEN-1];
        dsr_neg   = in_signed & divisor[XLEN-1];

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (divisor == '0) begin
                        result_d = in_rem ? dividend : '1;
                        state_d  = DONE;
                    end else if (in_signed && dividend == MIN_NEG && divisor == '1) begin
                        result_d = in_rem ? '0 : dividend;
                        state_d  = DONE;
                    end else begin
                        // Magnitudes fit in XLEN bits; -MIN_NEG wraps to itself, read as unsigned.
                        quo_d    = dvd_neg ? -dividend : dividend;
                        dsr_d    = dsr_neg ? -divisor : divisor;
                        rem_d    = '0;
                        count_d  = '0;
                        qneg_d   = dvd_neg ^ dsr_neg;
                        rneg_d   = dvd_neg;
                        is_rem_d = in_rem;
                        state_d  = RUN;
                    end
                end
            end
            RUN: begin
                rem_d = rem_nx;
                quo_d = quo_nx;
                if (count_q == CW'(XLEN - 1)) begin
                    count_d  = '0;
                    state_d  = DONE;
                    if (is_rem_q)
                        result_d = rneg_q ? -rem_nx : rem_nx;
                    else
                        result_d = qneg_q ? -quo_nx : quo_nx;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            count_q  <= '0;
            rem_q    <= '0;
            quo_q    <= '0;
            dsr_q    <= '0;
            result_q <= '0;
            qneg_q   <= 1'b0;
            rneg_q   <= 1'b0;
            is_rem_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            rem_q    <= rem_d;
            quo_q    <= quo_d;
            dsr_q    <= dsr_d;
            result_q <= result_d;
            qneg_q   <= qneg_d;
            rneg_q   <= rneg_d;
            is_rem_q <= is_rem_d;
        end
    end

    assign busy   = (state_q != IDLE);
    assign done   = (state_q == DONE);
    assign result = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: results, latency, handshake, ignored starts and mid-run reset.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [63:0] dividend;
    logic [63:0] divisor;
    logic        busy;
    logic        done;
    logic [63:0] result;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_unit #(.XLEN(64)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .result   (result)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request and follow it to completion. lat counts edges from the
    // capturing edge to the edge that raised done (0 = done right after capture).
    task automatic do_op(input logic [1:0] o, input logic [63:0] a, input logic [63:0] b,
                         output logic [63:0] res, output int lat,
                         output logic bsy_done, output logic bsy_after, output logic dn_after,
                         output logic [63:0] res_after);
        @(negedge clk);
        start = 1'b1; op = o; dividend = a; divisor = b;
        @(negedge clk);
        start = 1'b0; dividend = 64'hDEAD_BEEF_0BAD_F00D; divisor = 64'h3;
        lat = 0;
        while (!done && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        res      = result;
        bsy_done = busy;
        @(negedge clk);
        bsy_after = busy;
        dn_after  = done;
        res_after = result;
    endtask

    task automatic run_check(input string tag, input logic [1:0] o, input logic [63:0] a,
                             input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
        logic [63:0] res, res_after;
        int          lat;
        logic        bd, ba, da;
        do_op(o, a, b, res, lat, bd, ba, da, res_after);
        check({tag, "_result"}, res, exp);
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_busy_in_done"}, {63'b0, bd}, 64'd1);
        check({tag, "_busy_after"}, {63'b0, ba}, 64'd0);
        check({tag, "_done_after"}, {63'b0, da}, 64'd0);
        check({tag, "_held"}, res_after, exp);
    endtask

    initial begin
        int n;
        int pulses;
        rst = 1'b1; start = 1'b0; op = 2'b00; dividend = '0; divisor = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_result", result, 64'd0);
        rst = 1'b0;

        run_check("divu_100_7", 2'b01, 64'd100, 64'd7, 64'd14, 64);
        run_check("remu_100_7", 2'b11, 64'd100, 64'd7, 64'd2, 64);
        run_check("div_m100_7", 2'b00, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFF2, 64);
        run_check("rem_m100_7", 2'b10, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64);
        run_check("div_by_zero", 2'b00, 64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_check("rem_by_zero", 2'b10, 64'h1234, 64'd0, 64'h1234, 0);
        run_check("div_ovf", 2'b00, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                  64'h8000_0000_0000_0000, 0);
        run_check("rem_ovf", 2'b10, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0);
        run_check("div_7_m2", 2'b00, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFD, 64);
        run_check("remu_big", 2'b11, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0001,
                  64'h7FFF_FFFF_FFFF_FFFE, 64);

        // Starts while busy (mid-run and in the done cycle) must be dropped.
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 64'd1000; divisor = 64'd10;
        @(negedge clk);
        start = 1'b0; dividend = 64'd5; divisor = 64'd5;
        n = 0;
        pulses = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            start = (n == 10 || n == 11);
        end
        check("ign_latency", 64'(n), 64'd64);
        check("ign_result", result, 64'd100);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("ign_busy_after", {63'b0, busy}, 64'd0);
        check("ign_done_after", {63'b0, done}, 64'd0);
        repeat (70) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("ign_extra_pulses", 64'(pulses), 64'd0);
        check("ign_result_held", result, 64'd100);

        // Reset in the middle of a run aborts it immediately.
        @(negedge clk);
        start = 1'b1; op = 2'b01; dividend = 64'd12345; divisor = 64'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_result", result, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (70) begin
            @(negedge clk);
            if (done) pulses++;
        end
        check("rst_no_pulse", 64'(pulses), 64'd0);

        run_check("divu_max_2", 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/div_unit.md
# div_unit

Iterative RV64M divider executing DIV, DIVU, REM and REMU.
- Consumes the two register-file read operands (read_data1 as dividend, read_data2 as divisor).
- Returns a 64-bit result that the core routes to the register-file write_data port.
- While busy is high, control holds the PC and suppresses reg_write; writeback occurs in the done cycle.
- Uses one-bit-per-cycle restoring division with a start/busy/done handshake.

## Interface
- XLEN, 64, operand and result width; must be a power of two, at least 8.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- op  input  2  operation, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- dividend  input  XLEN  rs1 value.
- divisor  input  XLEN  rs2 value.
- busy  output  1  high whenever the unit is not idle, including the done cycle.
- done  output  1  one-cycle pulse; result is valid while it is high.
- result  output  XLEN  quotient or remainder; held until the next accepted start.

## Operation
- States and transitions:
  - IDLE: if start=1 at a clock edge, capture op and operands, then:
    - go to DONE if a special case applies;
    - otherwise go to RUN with count=0.
  - RUN: one restoring step per edge. After XLEN steps, go to DONE with result registered.
  - DONE: return to IDLE on the next edge.
- Signed ops (DIV, REM):
  - Divide absolute values using unsigned restoring division.
  - Quotient is negated when the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Magnitudes are XLEN bits, computed as two's-complement absolute values. 2^(XLEN-1) is handled as unsigned.
- Restoring step:
  - rem = {rem[XLEN-2:0], q[XLEN-1]}.
  - q shifts left by one.
  - If rem is greater than or equal to the divisor magnitude: subtract the divisor from rem and set q[0]=1.
  - Use an XLEN+1-bit subtract.
- Special cases, resolved without iteration:
  - Divisor = 0:
    - DIV and DIVU return all ones.
    - REM and REMU return the dividend.
  - Signed overflow (DIV or REM with dividend = 1 followed by zeros, divisor = all ones):
    - DIV returns the dividend.
    - REM returns 0.
  - Divisor = 0 takes priority over overflow.
- start while busy, including the done cycle, is ignored. No queuing.
- Inputs may change freely after the capturing edge.

## Timing
- Reset values: state IDLE, busy=0, done=0, result=0, count=0, internal registers 0. Reset takes effect immediately, without waiting for a clock edge.
- Reset during RUN or DONE aborts the operation; no done pulse is produced.
- Normal latency:
  - Start captured at edge E0.
  - busy rises after E0.
  - The final step occurs at E(XLEN); done and result are valid from E(XLEN) until E(XLEN+1).
  - busy falls at E(XLEN+1).
  - For XLEN=64: 65 busy cycles.
- Special-case latency:
  - done is high from E0 to E1.
  - busy falls at E1.
- Back-to-back operation: the earliest next start is sampled at the edge ending the done cycle's successor, i.e. the first IDLE cycle.
- Iteration counter width is $clog2(XLEN)+1. The counter does not wrap; it is compared against XLEN-1 to exit RUN.

## Structure
- The shared riscv_pkg holds:
  - localparams OP_DIV=2'b00, OP_DIVU=2'b01, OP_REM=2'b10, OP_REMU=2'b11;
  - the div_state_t typedef (IDLE, RUN, DONE).
- Single module, no sub-module. The step logic is inline combinational next-state code.

## Test plan
- DIVU 100/7 → result 14, done exactly 64 cycles after busy rises. REMU 100/7 → 2.
- DIV 0xFFFFFFFFFFFFFF9C (−100) / 7 → 0xFFFFFFFFFFFFFFF2 (−14). REM with the same operands → 0xFFFFFFFFFFFFFFFE (−2).
- DIV 0x1234/0 → 0xFFFFFFFFFFFFFFFF. REM 0x1234/0 → 0x1234. In both cases done is high in the cycle after start and busy is low one cycle later.
- DIV 0x8000000000000000 / 0xFFFFFFFFFFFFFFFF → 0x8000000000000000. REM with the same operands → 0. Both complete with 1-cycle latency.
- Start DIVU 1000/10, then re-assert start with 5/5 during RUN and during done → both re-assertions are ignored; result 100 with a single done pulse.
- Assert rst 30 cycles into a DIVU → busy, done and result are 0 immediately with no done pulse. A subsequent DIVU 0xFFFFFFFFFFFFFFFF/2 → 0x7FFFFFFFFFFFFFFF with normal latency.
